// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO port, its bus interface and the testbench.
package gpio_pkg;

    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t REG_DATA_OUT   = 3'd0;
    localparam addr_t REG_DATA_IN    = 3'd1;
    localparam addr_t REG_DIR        = 3'd2;
    localparam addr_t REG_IRQ_EN     = 3'd3;
    localparam addr_t REG_IRQ_STATUS = 3'd4;
    localparam addr_t REG_EDGE_SEL   = 3'd5;

endpackage

// File: rtl/gpio_if.sv
// Register-bus interface between a bus master and gpio_port.
interface gpio_if;
    import gpio_pkg::*;

    addr_t       addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    // Strobes are sampled on every rising clk with no backpressure: a write
    // lands on that edge, and each rd_en yields exactly one rvalid pulse with
    // rdata on the next cycle. rdata is 0 whenever rvalid is 0.
    modport master (output addr, wr_en, rd_en, wdata, input rdata, rvalid);
    modport slave  (input addr, wr_en, rd_en, wdata, output rdata, rvalid);

endinterface

// File: rtl/gpio_in_cond.sv
// One input pin: synchronizer, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
module gpio_in_cond #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Count consecutive cycles of disagreement; any agreement restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync_lvl == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            level_q <= sync_lvl;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = level_q;
`else
    assign level = sync_lvl;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/gpio_port.sv
// GPIO port: register file, per-pin input conditioning and level interrupt.
// Build with GPIO_DEBOUNCE_EN defined to insert per-pin debounce counters.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    gpio_if.slave            bus,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, dir_q, irq_en_q, irq_status_q, edge_sel_q;
    logic [WIDTH-1:0] pin_level, pin_rise, pin_fall;
    logic [WIDTH-1:0] edge_evt, wmask, w1c;
    logic [31:0]      rd_mux, rdata_q;
    logic             rvalid_q, irq_q;

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("gpio_port: parameter out of range");
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^bus.wdata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_cond #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_cond (
            .clk  (clk),
            .rst  (rst),
            .pin  (gpio_i[i]),
            .level(pin_level[i]),
            .rise (pin_rise[i]),
            .fall (pin_fall[i])
        );
    end

    assign wmask    = bus.wdata[WIDTH-1:0];
    assign w1c      = (bus.wr_en && bus.addr == REG_IRQ_STATUS) ? wmask : '0;
    // Events come from real level transitions only, so reprogramming DIR or
    // EDGE_SEL never fabricates one.
    assign edge_evt = ~dir_q & ((~edge_sel_q & pin_rise) | (edge_sel_q & pin_fall));

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            REG_DATA_OUT:   rd_mux[WIDTH-1:0] = data_out_q;
            REG_DATA_IN:    rd_mux[WIDTH-1:0] = pin_level;
            REG_DIR:        rd_mux[WIDTH-1:0] = dir_q;
            REG_IRQ_EN:     rd_mux[WIDTH-1:0] = irq_en_q;
            REG_IRQ_STATUS: rd_mux[WIDTH-1:0] = irq_status_q;
            REG_EDGE_SEL:   rd_mux[WIDTH-1:0] = edge_sel_q;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            edge_sel_q   <= '0;
            irq_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (bus.wr_en) begin
                case (bus.addr)
                    REG_DATA_OUT: data_out_q <= wmask;
                    REG_DIR:      dir_q      <= wmask;
                    REG_IRQ_EN:   irq_en_q   <= wmask;
                    REG_EDGE_SEL: edge_sel_q <= wmask;
                    default:      ;
                endcase
            end
            // A new event wins over a same-cycle clear.
            irq_status_q <= (irq_status_q & ~w1c) | edge_evt;
            irq_q        <= |(irq_status_q & irq_en_q);
            rvalid_q     <= bus.rd_en;
            rdata_q      <= bus.rd_en ? rd_mux : '0;
        end
    end

    assign gpio_o     = data_out_q;
    assign gpio_oe    = dir_q;
    assign irq        = irq_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: register table, directed corner cases and
// randomized traffic against a reference model (debounce checks under GPIO_DEBOUNCE_EN).
module tb_gpio_port;
    import gpio_pkg::*;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = D;
`else
    localparam int DB = 0;
`endif
    // clock edges from a pin change (driven before edge 1) to its status bit setting
    localparam int LAT = S + DB + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] gpio_i;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int total = 0;
    int bad   = 0;

    gpio_if bus ();

    gpio_port #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .gpio_oe(gpio_oe),
        .irq    (irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [W-1:0] m_out, m_dir, m_en, m_sts, m_sel, m_level, m_prev, m_sync;
    logic         m_irq, m_rvalid;
    logic [31:0]  m_rdata;
    logic [W-1:0] pin_q[$];
    logic [W-1:0] sync_hist[$];

    function automatic logic [31:0] m_read(input addr_t a);
        case (a)
            REG_DATA_OUT:   return 32'(m_out);
            REG_DATA_IN:    return 32'(m_level);
            REG_DIR:        return 32'(m_dir);
            REG_IRQ_EN:     return 32'(m_en);
            REG_IRQ_STATUS: return 32'(m_sts);
            REG_EDGE_SEL:   return 32'(m_sel);
            default:        return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_sts = '0; m_sel = '0;
        m_level = '0; m_prev = '0; m_sync = '0;
        m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        pin_q = {};
        sync_hist = {};
        for (int k = 0; k < S; k++) pin_q.push_back('0);
    endtask

    // Advance the model across one rising edge using the inputs held at that edge.
    task automatic model_step();
        logic [W-1:0] w, rise, fall, ev, new_level;
        w    = bus.wdata[W-1:0];
        rise = m_level & ~m_prev;
        fall = ~m_level & m_prev;
        ev   = ~m_dir & ((~m_sel & rise) | (m_sel & fall));
        m_rvalid = bus.rd_en;
        m_rdata  = bus.rd_en ? m_read(bus.addr) : 32'd0;
        m_irq    = |(m_sts & m_en);
        if (bus.wr_en && bus.addr == REG_IRQ_STATUS) m_sts = m_sts & ~w;
        m_sts = m_sts | ev;
        if (bus.wr_en) begin
            case (bus.addr)
                REG_DATA_OUT: m_out = w;
                REG_DIR:      m_dir = w;
                REG_IRQ_EN:   m_en  = w;
                REG_EDGE_SEL: m_sel = w;
                default:      ;
            endcase
        end
        new_level = m_level;
`ifdef GPIO_DEBOUNCE_EN
        // level flips once the last D synchronized samples all disagree with it
        sync_hist.push_back(m_sync);
        if (sync_hist.size() > D) void'(sync_hist.pop_front());
        if (sync_hist.size() == D) begin
            for (int b = 0; b < W; b++) begin
                logic stable;
                stable = 1'b1;
                for (int k = 1; k < D; k++)
                    if (sync_hist[k][b] != sync_hist[0][b]) stable = 1'b0;
                if (stable && sync_hist[0][b] != m_level[b]) new_level[b] = sync_hist[0][b];
            end
        end
`endif
        pin_q.push_back(gpio_i);
        void'(pin_q.pop_front());
        m_sync = pin_q[0];
`ifndef GPIO_DEBOUNCE_EN
        new_level = m_sync;
`endif
        m_prev  = m_level;
        m_level = new_level;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("gpio_o",  32'(gpio_o),  32'(m_out));
        check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        check("irq",     32'(irq),     32'(m_irq));
        check("rvalid",  32'(bus.rvalid), 32'(m_rvalid));
        check("rdata",   bus.rdata,    m_rdata);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic write(input addr_t a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cycle();
        idle();
    endtask

    task automatic read(input addr_t a, output logic [31:0] d);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        cycle();
        d = bus.rdata;
        check("read_rvalid", 32'(bus.rvalid), 32'd1);
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gpio_o"},  32'(gpio_o),  32'd0);
        check({tag, "_gpio_oe"}, 32'(gpio_oe), 32'd0);
        check({tag, "_irq"},     32'(irq),     32'd0);
        check({tag, "_rvalid"},  32'(bus.rvalid), 32'd0);
        check({tag, "_rdata"},   bus.rdata,    32'd0);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        addr_t        waddr;
        logic [31:0]  wdata;
        addr_t        raddr;
        logic [31:0]  exp_rd;
        logic [W-1:0] exp_o;
        logic [W-1:0] exp_oe;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] d;

        vecs[0] = '{REG_DIR,        32'h0000_00FF, REG_DIR,        32'h0000_00FF, 8'h00, 8'hFF};
        vecs[1] = '{REG_DATA_OUT,   32'h0000_00A5, REG_DATA_OUT,   32'h0000_00A5, 8'hA5, 8'hFF};
        vecs[2] = '{REG_IRQ_EN,     32'h0000_01F3, REG_IRQ_EN,     32'h0000_00F3, 8'hA5, 8'hFF};
        vecs[3] = '{REG_EDGE_SEL,   32'hFFFF_FF3C, REG_EDGE_SEL,   32'h0000_003C, 8'hA5, 8'hFF};
        vecs[4] = '{REG_DATA_IN,    32'h0000_0055, REG_DATA_IN,    32'h0000_0000, 8'hA5, 8'hFF};
        vecs[5] = '{3'd6,           32'hFFFF_FFFF, 3'd6,           32'h0000_0000, 8'hA5, 8'hFF};
        vecs[6] = '{3'd7,           32'hFFFF_FFFF, REG_DATA_OUT,   32'h0000_00A5, 8'hA5, 8'hFF};
        vecs[7] = '{REG_IRQ_STATUS, 32'h0000_00FF, REG_IRQ_STATUS, 32'h0000_0000, 8'hA5, 8'hFF};
        vecs[8] = '{REG_DIR,        32'h0000_0000, REG_DIR,        32'h0000_0000, 8'hA5, 8'h00};
        vecs[9] = '{REG_DATA_OUT,   32'h0000_005A, REG_DATA_OUT,   32'h0000_005A, 8'h5A, 8'h00};

        // reset block
        gpio_i = '0;
        idle();
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) cycle();

        // table-driven register access
        for (int i = 0; i < 10; i++) begin
            write(vecs[i].waddr, vecs[i].wdata);
            check($sformatf("vec%0d_gpio_o", i),  32'(gpio_o),  32'(vecs[i].exp_o));
            check($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            read(vecs[i].raddr, d);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
        end

        // same-cycle read and write returns the pre-write value
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = REG_DATA_OUT; bus.wdata = 32'h33;
        cycle();
        check("rw_same_pre", bus.rdata, 32'h5A);
        idle();
        read(REG_DATA_OUT, d);
        check("rw_same_post", d, 32'h33);

        // rising edge on bit 3 -> status after LAT edges, irq one edge later
        write(REG_EDGE_SEL, 32'h0);
        write(REG_IRQ_EN, 32'h08);
        write(REG_IRQ_STATUS, 32'hFF);
        gpio_i[3] = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            cycle();
            if (c == LAT)     check("irq_before", 32'(irq), 32'd0);
            if (c == LAT + 1) check("irq_after",  32'(irq), 32'd1);
        end
        read(REG_IRQ_STATUS, d);
        check("sts_bit3", d, 32'h08);
        write(REG_IRQ_STATUS, 32'h08);
        cycle();
        check("irq_w1c", 32'(irq), 32'd0);

        // W1C on the same edge that a new rising event lands on bit 3
        gpio_i[3] = 1'b0;
        repeat (LAT + 2) cycle();
        read(REG_IRQ_STATUS, d);
        check("fall_not_sel", d, 32'h0);
        gpio_i[3] = 1'b1;
        repeat (LAT - 1) cycle();
        write(REG_IRQ_STATUS, 32'h08);
        read(REG_IRQ_STATUS, d);
        check("w1c_vs_edge", d, 32'h08);
        write(REG_IRQ_STATUS, 32'h08);

        // reprogramming EDGE_SEL/DIR on a steady pin raises nothing
        write(REG_EDGE_SEL, 32'h08);
        write(REG_DIR, 32'h08);
        write(REG_DIR, 32'h00);
        repeat (3) cycle();
        read(REG_IRQ_STATUS, d);
        check("cfg_no_event", d, 32'h0);
        write(REG_EDGE_SEL, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // debounce: 3-cycle glitch filtered, 6-cycle pulse accepted
        write(REG_IRQ_EN, 32'h01);
        gpio_i[0] = 1'b1;
        repeat (3) cycle();
        gpio_i[0] = 1'b0;
        repeat (10) cycle();
        read(REG_DATA_IN, d);
        check("glitch_data_in", d, 32'h08);
        read(REG_IRQ_STATUS, d);
        check("glitch_status", d, 32'h0);
        gpio_i[0] = 1'b1;
        repeat (6) cycle();
        gpio_i[0] = 1'b0;
        read(REG_DATA_IN, d);
        check("pulse_data_in", d, 32'h09);
        read(REG_IRQ_STATUS, d);
        check("pulse_status", d, 32'h01);
        repeat (10) cycle();
        write(REG_IRQ_STATUS, 32'hFF);
`endif

        // reset with a read in flight and every register nonzero
        write(REG_DATA_OUT, 32'hFF);
        write(REG_DIR, 32'h0F);
        write(REG_IRQ_EN, 32'hFF);
        gpio_i[4] = 1'b1;
        repeat (LAT + 2) cycle();
        write(REG_EDGE_SEL, 32'h80);
        check("pre_rst_irq", 32'(irq), 32'd1);
        bus.rd_en = 1'b1;
        bus.addr  = REG_DATA_OUT;
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < LAT + 3; c++) begin
            cycle();
            check("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.addr  = addr_t'($urandom_range(0, 7));
            bus.wdata = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                int b;
                b = $urandom_range(0, W - 1);
                gpio_i[b] = ~gpio_i[b];
            end
            cycle();
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter WIDTH, default 8, is the number of GPIO pins (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, is the input synchronizer depth (2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, is the stable-cycle count required when debounce is compiled in (2..255).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 addr  input  3  word index: 0 DATA_OUT, 1 DATA_IN, 2 DIR, 3 IRQ_EN, 4 IRQ_STATUS, 5 EDGE_SEL; 6-7 unmapped.
REQ-007 wr_en  input  1  write strobe, qualified by addr and wdata in the same cycle.
REQ-008 rd_en  input  1  read strobe.
REQ-009 wdata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 rdata  output  32  read data, zero-extended above WIDTH-1.
REQ-011 rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-012 gpio_i  input  WIDTH  asynchronous pin inputs.
REQ-013 gpio_o  output  WIDTH  pin output values.
REQ-014 gpio_oe  output  WIDTH  per-pin output enable; 1 = driven.
REQ-015 irq  output  1  level interrupt, OR of (IRQ_STATUS & IRQ_EN).

Function
REQ-016 gpio_i SHALL pass through SYNC_STAGES flops before any use; pin level = last stage.
REQ-017 Writes SHALL take effect on the clk edge where wr_en=1; gpio_o/gpio_oe reflect them the following cycle.
REQ-018 Read latency SHALL be 1 cycle: rd_en in cycle N gives rdata and rvalid=1 in N+1; rdata SHALL be 0 when rvalid=0.
REQ-019 DATA_IN reads SHALL return the synchronized (debounced if enabled) level for all pins, regardless of DIR.
REQ-020 Writes to DATA_IN and to unmapped addresses SHALL be ignored; unmapped reads return 0 with rvalid=1.
REQ-021 An edge event per pin SHALL be detected on the conditioned level: EDGE_SEL bit 0 = rising, 1 = falling, only when the pin's DIR bit is 0.
REQ-022 An edge event SHALL set its IRQ_STATUS bit one cycle after the conditioned level changes, independent of IRQ_EN.
REQ-023 Writing IRQ_STATUS SHALL clear bits where wdata is 1 (W1C); 0 bits unchanged.
REQ-024 Simultaneous W1C and new edge on the same bit SHALL leave the bit set.
REQ-025 rd_en and wr_en in the same cycle to the same address SHALL return the pre-write value.
REQ-026 Changing EDGE_SEL or DIR SHALL NOT itself generate an edge event.
REQ-027 irq SHALL be registered, asserting one cycle after the status/enable condition becomes true.

Reset
REQ-028 On rst=1, immediately and asynchronously: DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, EDGE_SEL, synchronizer and debounce state = 0; gpio_o=0, gpio_oe=0, irq=0, rvalid=0, rdata=0.
REQ-029 rst asserted mid-transaction SHALL discard the pending read; no rvalid after release.
REQ-030 First cycle after release SHALL NOT report an edge from reset-state synchronizer values.

Configuration
REQ-031 Macro GPIO_DEBOUNCE_EN defined: each input pin's conditioned level updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-032 Macro GPIO_DEBOUNCE_EN undefined: conditioned level = synchronized level; no debounce counters synthesized; DEBOUNCE_CYCLES unused.

Structure
REQ-033 Package gpio_pkg SHALL hold the register index constants and the 3-bit address width.
REQ-034 Sub-module gpio_in_cond SHALL implement one pin's synchronizer, optional debounce and edge detect, instantiated WIDTH times.

Verification
REQ-035 WIDTH=8: write DIR=0xFF, DATA_OUT=0xA5 -> gpio_oe=0xFF, gpio_o=0xA5 next cycle; readback 0xA5 with rvalid 1 cycle after rd_en.
REQ-036 No debounce: gpio_i bit3 0->1, EDGE_SEL=0, IRQ_EN=0x08 -> IRQ_STATUS=0x08 at SYNC_STAGES+1 cycles, irq one cycle later; W1C 0x08 -> irq=0.
REQ-037 Same-cycle W1C of bit 3 and new rising edge on bit 3 -> IRQ_STATUS bit 3 stays 1.
REQ-038 GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle glitch on bit 0 -> DATA_IN bit 0 unchanged, no event; 6-cycle pulse -> DATA_IN updates, event set.
REQ-039 rst asserted between rd_en and rvalid with all registers nonzero -> all outputs 0 asynchronously, no rvalid after release.
REQ-040 Write/read addr 6 with 0xFFFFFFFF -> no state change, rdata=0, rvalid=1.
